// File: rtl/tm1638_pkg.sv
// TM1638 shared definitions.
// Command byte, FSM states and the key-scan decode helper.
`timescale 1ns/1ps
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam int NUM_READ_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    WAIT,
    READ,
    FINISH
  } state_t;

  // Keys live in bit0 and bit4 of each scan byte.
  function automatic logic [7:0] decode_keys(
    input logic [31:0] r
  );
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < NUM_READ_BYTES; i++) begin
      k[i]   = r[8*i];
      k[i+4] = r[8*i+4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Half-period timer for the TM1638 serial clock.
// Strobes mark cell positions given the current clk1 level.
`timescale 1ns/1ps
module tm1638_bit_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic lvl,
  output logic fall_tick,
  output logic rise_tick,
  output logic low_end,
  output logic cell_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic first;
  logic last;

  // Count system clocks within the current half period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign first     = (cnt == '0);
  assign last      = (cnt == LAST);
  assign fall_tick = en && first && !lvl;
  assign rise_tick = en && first && lvl;
  assign low_end   = en && last && !lvl;
  assign cell_end  = en && last && lvl;

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader.
// Sends read command 0x42, then shifts in four scan bytes.
`timescale 1ns/1ps
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int WAIT_CYC = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dio_in,
  output logic        stb,
  output logic        clk1,
  output logic        dio_out,
  output logic        dio_oe,
  output logic        busy,
  output logic        done,
  output logic [31:0] raw,
  output logic [7:0]  keys
);

  localparam int WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WAIT_CYC - 1);
  localparam logic [5:0] CMD_BITS = 6'd8;
  localparam logic [5:0] RD_BITS = 6'(NUM_READ_BYTES * 8);

  state_t      state;
  logic [5:0]  idx;
  logic [WW-1:0] wcnt;
  logic [31:0] shreg;
  logic        tmr_en;
  logic        fall_tick;
  logic        rise_tick;
  logic        low_end;
  logic        cell_end;

  assign tmr_en = (state == SETUP) ||
                  (state == CMD) ||
                  (state == READ);

  tm1638_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (tmr_en),
    .lvl      (clk1),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick),
    .low_end  (low_end),
    .cell_end (cell_end)
  );

  // Transfer sequencer; every pad and status output is registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      stb     <= 1'b1;
      clk1    <= 1'b1;
      dio_out <= 1'b1;
      dio_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      raw     <= '0;
      keys    <= '0;
      idx     <= '0;
      wcnt    <= '0;
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            stb     <= 1'b0;
            busy    <= 1'b1;
            dio_oe  <= 1'b1;
            dio_out <= 1'b1;
            clk1    <= 1'b1;
            shreg   <= '0;
          end
        end
        SETUP: begin
          if (cell_end) begin
            state   <= CMD;
            clk1    <= 1'b0;
            dio_out <= CMD_READ_KEYS[0];
            idx     <= '0;
          end
        end
        CMD: begin
          if (fall_tick) idx <= idx + 6'd1;
          if (low_end) clk1 <= 1'b1;
          if (cell_end) begin
            if (idx == CMD_BITS) begin
              state  <= WAIT;
              dio_oe <= 1'b0;
              wcnt   <= '0;
            end else begin
              clk1    <= 1'b0;
              dio_out <= CMD_READ_KEYS[idx[2:0]];
            end
          end
        end
        WAIT: begin
          if (wcnt == WLAST) begin
            state <= READ;
            clk1  <= 1'b0;
            idx   <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        READ: begin
          if (fall_tick) idx <= idx + 6'd1;
          if (low_end) clk1 <= 1'b1;
          if (rise_tick) shreg <= {dio_in, shreg[31:1]};
          if (cell_end) begin
            if (idx == RD_BITS) begin
              state <= FINISH;
              stb   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              raw   <= shreg;
              keys  <= decode_keys(shreg);
            end else begin
              clk1 <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader.
// Includes a small TM1638 read-side device model.
`timescale 1ns/1ps
module tb_tm1638_key_reader;

  localparam int CD  = 2;
  localparam int WC  = 4;
  localparam int LAT = 167;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dio_in;
  logic        stb;
  logic        clk1;
  logic        dio_out;
  logic        dio_oe;
  logic        busy;
  logic        done;
  logic [31:0] raw;
  logic [7:0]  keys;

  always #5 clk = ~clk;

  tm1638_key_reader #(
    .CLK_DIV (CD),
    .WAIT_CYC(WC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dio_in (dio_in),
    .stb    (stb),
    .clk1   (clk1),
    .dio_out(dio_out),
    .dio_oe (dio_oe),
    .busy   (busy),
    .done   (done),
    .raw    (raw),
    .keys   (keys)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Device model: one bit per clk1 fall after the 8 command cells.
  logic [31:0] rd_data = '0;
  int   nfall = 0;
  logic model_bit;

  always @(negedge stb) nfall = 0;
  always @(negedge clk1) if (!stb) nfall++;

  always_comb begin
    model_bit = 1'b1;
    if (nfall >= 9 && nfall <= 40)
      model_bit = rd_data[5'(nfall - 9)];
  end

  assign dio_in = dio_oe ? dio_out : model_bit;

  // Bus monitors.
  int rises = 0;
  int cmd_n = 0;
  logic [7:0] cmd_bits = '0;
  int oe_fall = 0;
  int done_cnt = 0;
  int viol = 0;

  always @(posedge clk1) begin
    if (!stb) begin
      rises++;
      if (dio_oe) begin
        cmd_bits = {dio_out, cmd_bits[7:1]};
        cmd_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!stb && !dio_oe && oe_fall == 0) oe_fall = cyc;
    if (!stb && dio_oe && nfall >= 9) viol++;
  end

  int errors = 0;
  int checks = 0;
  int cs = 0;
  int at = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cs = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clr_mon();
    rises = 0;
    cmd_n = 0;
    cmd_bits = '0;
    oe_fall = 0;
    done_cnt = 0;
    viol = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and quiet idle
    rst = 1'b0;
    tick(2);
    check("rst_stb", 32'(stb), 32'd1);
    check("rst_clk1", 32'(clk1), 32'd1);
    check("rst_dio_out", 32'(dio_out), 32'd1);
    check("rst_dio_oe", 32'(dio_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raw", raw, 32'd0);
    check("rst_keys", 32'(keys), 32'd0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (stb !== 1'b1 || clk1 !== 1'b1 || dio_oe !== 1'b0 ||
          busy !== 1'b0 || keys !== 8'h00 || done !== 1'b0)
        bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // 2/3: full transfer
    clr_mon();
    rd_data = 32'h1100_1001;
    pulse_start();
    check("setup_stb", 32'(stb), 32'd0);
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_oe", 32'(dio_oe), 32'd1);
    wait_done(400, at);
    check("t3_latency", 32'(at - cs), 32'(LAT));
    check("t3_raw", raw, 32'h1100_1001);
    check("t3_keys", 32'(keys), 32'hA9);
    check("t2_cmd_byte", 32'(cmd_bits), 32'h42);
    check("t2_cmd_bits", 32'(cmd_n), 32'd8);
    check("t2_rises", 32'(rises), 32'd40);
    check("t2_oe_fall", 32'(oe_fall - cs), 32'd35);
    check("t2_no_drive_read", 32'(viol), 32'd0);
    check("t3_busy_at_done", 32'(busy), 32'd0);
    check("t3_stb_at_done", 32'(stb), 32'd1);
    tick(5);
    check("t3_done_pulse", 32'(done_cnt), 32'd1);

    // 4: starts during a transfer are ignored
    clr_mon();
    rd_data = 32'h0011_0110;
    pulse_start();
    bad = 0;
    for (int i = 1; i <= 166; i++) begin
      if (busy !== 1'b1) bad++;
      start = (i == 20 || i == 100);
      @(negedge clk);
    end
    start = 1'b0;
    check("t4_done_at_lat", 32'(done), 32'd1);
    check("t4_raw", raw, 32'h0011_0110);
    check("t4_keys", 32'(keys), 32'h56);
    tick(300);
    check("t4_busy_held", 32'(bad), 32'd0);
    check("t4_one_done", 32'(done_cnt), 32'd1);
    check("t4_stb_idle", 32'(stb), 32'd1);

    // 5: reset during READ bit 10
    clr_mon();
    rd_data = 32'hDEAD_BEEF;
    pulse_start();
    tick(79);
    check("t5_in_read_oe", 32'(dio_oe), 32'd0);
    check("t5_in_read_stb", 32'(stb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_stb", 32'(stb), 32'd1);
    check("t5_clk1", 32'(clk1), 32'd1);
    check("t5_oe", 32'(dio_oe), 32'd0);
    check("t5_raw", raw, 32'd0);
    check("t5_keys", 32'(keys), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick(300);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    clr_mon();
    rd_data = 32'h1100_1001;
    pulse_start();
    wait_done(400, at);
    check("t5_re_latency", 32'(at - cs), 32'(LAT));
    check("t5_re_raw", raw, 32'h1100_1001);
    check("t5_re_keys", 32'(keys), 32'hA9);

    // 6: start held over FINISH and first IDLE cycle
    rd_data = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    cs = cyc;
    @(negedge clk);
    start = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    tick(99);
    check("t6_keys_held", 32'(keys), 32'hA9);
    check("t6_raw_held", raw, 32'h1100_1001);
    wait_done(200, at);
    check("t6_latency", 32'(at - cs), 32'(LAT));
    check("t6_raw", raw, 32'hFFFF_FFFF);
    check("t6_keys", 32'(keys), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm1638_key_reader.md
Name: tm1638_key_reader

Overview:
- Reads the 8-button key matrix from the TM1638 display/keypad controller: the read direction of the same serial link (stb, clk1, dio) that the display FSM uses for writes.
- On a start pulse it drives STB low, sends read command 0x42 LSB-first, releases DIO and clocks in 4 key-scan bytes.
- It then returns the raw 32-bit scan and a decoded 8-bit key vector.
- Bus sharing with the display FSM is handled one level up; that mux switches only while both blocks have busy=0.

Parameters:
- CLK_DIV, 50: system clocks per clk1 half-period (100 MHz -> 1 MHz clk1); legal range >= 2.
- WAIT_CYC, 200: system clocks clk1 is held high between the command byte and the first read bit (TM1638 Twait >= 1 us); legal range >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle request to perform one key read
- dio_in  in  1  DIO pad input (pad has an external pull-up)
- stb  out  1  TM1638 STB, active-low
- clk1  out  1  TM1638 CLK, idles high
- dio_out  out  1  DIO drive value
- dio_oe  out  1  1 = drive dio_out onto the pad, 0 = release the pad
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; keys/raw valid from this cycle
- raw  out  32  scan bytes, byte0 in [7:0] through byte3 in [31:24]
- keys  out  8  keys[i] = byte_i bit0, keys[i+4] = byte_i bit4, for i = 0..3

Behaviour:
- Reset (rst=0 at a clk edge):
  - outputs: stb=1, clk1=1, dio_out=1, dio_oe=0, busy=0, done=0, raw=0, keys=0; FSM returns to IDLE.
  - Reset mid-transfer aborts immediately: no done, and raw/keys are cleared.
- States: IDLE -> SETUP -> CMD -> WAIT -> READ -> FINISH -> IDLE.
- IDLE:
  - start=1 -> SETUP on the next cycle, with stb=0, busy=1, dio_oe=1, dio_out=1.
  - start while busy=1 is ignored; it is not queued.
- SETUP: hold for CLK_DIV cycles, then -> CMD.
- CMD: 8 bit cells of 0x42, LSB first.
  - Each cell: clk1=0 for CLK_DIV cycles, then clk1=1 for CLK_DIV cycles.
  - dio_out takes the bit value in the cycle clk1 falls and holds it for the whole cell.
- WAIT:
  - dio_oe=0 from the cycle after the 8th high phase ends.
  - clk1 stays 1 for WAIT_CYC cycles, then -> READ.
- READ: 32 bit cells with the same clk1 timing as CMD.
  - dio_in is sampled in the first cycle of each clk1-high phase.
  - Samples shift in LSB first; cell n lands in internal shift bit n.
- FINISH (one cycle after the last high phase):
  - stb=1, busy=0, done=1.
  - raw and keys load from the shift register in this same cycle, then -> IDLE.
- raw/keys hold their value until the next done or reset.
- Latency: start sampled at cycle T -> done at T+1+81*CLK_DIV+WAIT_CYC.
  - Example: CLK_DIV=2, WAIT_CYC=4 -> done at T+167.
- A start in the same cycle as done/FINISH is ignored; start is accepted again from the first IDLE cycle.
- Counters:
  - half-period counter: $clog2(CLK_DIV) bits
  - wait counter: $clog2(WAIT_CYC+1) bits
  - bit index: 6 bits, wrapping is never needed.
- dio_oe=0 during all READ cycles; the block never drives the pad while the TM1638 is outputting.

Decomposition:
- Package tm1638_pkg:
  - CMD_READ_KEYS = 8'h42
  - state enum (IDLE, SETUP, CMD, WAIT, READ, FINISH)
  - NUM_READ_BYTES = 4
  - key-decode function from raw[31:0] to keys[7:0]
- Sub-module tm1638_bit_timer:
  - CLK_DIV half-period counter producing fall_tick, rise_tick and cell_end strobes.
  - Shared later with the display FSM.

Test Plan:
1. Reset held 2 cycles, no start -> stb=1, clk1=1, dio_oe=0, busy=0, keys=0 for 500 cycles.
2. With CLK_DIV=2, WAIT_CYC=4, start=1 for one cycle:
   - dio_out bits captured on clk1 rising while dio_oe=1 read 0,1,0,0,0,0,1,0 (0x42);
   - dio_oe falls right after the 8th cell;
   - exactly 40 clk1 rising edges occur while stb=0.
3. Device model returns bytes 0x01, 0x10, 0x00, 0x11 -> raw=32'h1100_1001, keys=8'hA9, done exactly 167 cycles after start.
4. Pulse start again at cycles +20 and +100 during a transfer -> ignored; exactly one done occurs, and busy stays high throughout.
5. Assert rst=0 during the READ phase (bit 10):
   - next cycle stb=1, clk1=1, dio_oe=0, raw=0, keys=0;
   - no done pulse;
   - a following start completes normally.
6. Start in the first IDLE cycle after done, model returns all 0xFF -> raw=32'hFFFF_FFFF, keys=8'hFF; the previous keys are held until the new done.
